// File: rtl/hexdisp_scan_if.sv
// hexdisp_scan_if: Wishbone-style register bus between a bus master and the
// hexdisp_scan register slave.
//
// Handshake: a request is cyc_i & stb_i while ack_o is low. The slave answers
// with a single-cycle ack_o on the following clock. dat_o is meaningful only
// while ack_o = 1. The master keeps cyc_i/stb_i/we_i/adr_i/sel_i/dat_i stable
// until it sees ack_o. A strobe without cyc_i is not a request.
//
// Signals:
//   cyc_i   bus cycle          stb_i  strobe          we_i  write enable
//   adr_i   register select    sel_i  byte lanes      dat_i write data
//   dat_o   read data          ack_o  acknowledge
interface hexdisp_scan_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [1:0]  adr_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
        output dat_o, ack_o
    );

    modport master (
        output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
        input  dat_o, ack_o
    );
endinterface

// File: rtl/hexdisp_scan.sv
// hexdisp_scan: register slave plus time-multiplexed hex display scanner.
// Holds a 32-bit value and a control word, and steps through DIGITS digit
// slots, presenting one {dp, nibble} code at a time to a shared 7-segment
// decoder together with an active-low one-hot anode vector.
//
// Ports:
//   clk_i      system clock
//   rst_i      synchronous, active-high reset
//   wb         register bus (slave side), see hexdisp_scan_if
//   digit_o    {dp, nibble} of the digit in the current slot
//   anode_n_o  active-low digit enable, at most one bit low
//
// Registers:
//   0  value[31:0]
//   1  control: [7:0] dp_mask, [8] lz_blank, [9] blink_en, [10] disp_en
//   2,3 read as zero, writes ignored
module hexdisp_scan #(
    parameter int DIGITS     = 8,
    parameter int PRESCALE   = 50000,
    parameter int BLINK_BITS = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    hexdisp_scan_if.slave     wb,
    output logic [4:0]        digit_o,
    output logic [DIGITS-1:0] anode_n_o
);

    localparam int PW = $clog2(PRESCALE);

    logic [31:0]           value;
    logic [10:0]           ctrl;
    logic [PW-1:0]         pre;
    logic [2:0]            idx;
    logic [BLINK_BITS-1:0] slot_cnt;
    logic                  upd;

    logic [7:0]  dp_mask;
    logic        lz_blank;
    logic        blink_en;
    logic        disp_en;
    logic        wrap;
    logic        req;
    logic [31:0] rd_data;
    logic        lz_hit;
    logic        zero_run;
    logic        suppress;

    assign dp_mask  = ctrl[7:0];
    assign lz_blank = ctrl[8];
    assign blink_en = ctrl[9];
    assign disp_en  = ctrl[10];
    assign wrap     = (pre == PW'(PRESCALE - 1));
    assign req      = wb.cyc_i & wb.stb_i & ~wb.ack_o;

    always_comb begin
        rd_data = '0;
        case (wb.adr_i)
            2'd0:    rd_data = value;
            2'd1:    rd_data = {21'b0, ctrl};
            default: rd_data = '0;
        endcase
    end

    // Walk from the top implemented digit down; zero_run stays high while
    // every nibble from the top down to position i is zero. The value seen
    // at the current slot index decides leading-zero blanking.
    always_comb begin
        lz_hit   = 1'b0;
        zero_run = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (i < DIGITS) begin
                zero_run = zero_run & (value[4*i +: 4] == 4'h0);
                if (3'(i) == idx) begin
                    lz_hit = zero_run;
                end
            end
        end
    end

    assign suppress = ~disp_en
                    | (blink_en & slot_cnt[BLINK_BITS-1])
                    | (lz_blank & (idx != 3'd0) & lz_hit & ~dp_mask[idx]);

    // Bus side: one request per two cycles at most, since ack_o blocks the
    // next request for a cycle. dat_o captures the contents before any write
    // performed on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            value     <= '0;
            ctrl      <= 11'h400;
            wb.ack_o  <= 1'b0;
            wb.dat_o  <= '0;
        end else begin
            wb.ack_o <= req;
            wb.dat_o <= req ? rd_data : '0;
            if (req && wb.we_i) begin
                if (wb.adr_i == 2'd0) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wb.sel_i[b]) begin
                            value[8*b +: 8] <= wb.dat_i[8*b +: 8];
                        end
                    end
                end else if (wb.adr_i == 2'd1) begin
                    if (wb.sel_i[0]) ctrl[7:0]  <= wb.dat_i[7:0];
                    if (wb.sel_i[1]) ctrl[10:8] <= wb.dat_i[10:8];
                end
            end
        end
    end

    // Scan side. upd marks "idx changed on the previous edge"; it comes out
    // of reset set so slot 0 is shown one cycle after reset. The outputs only
    // load on upd, so register writes never change a slot mid-way.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre       <= '0;
            idx       <= '0;
            slot_cnt  <= '0;
            upd       <= 1'b1;
            digit_o   <= '0;
            anode_n_o <= '1;
        end else begin
            upd <= wrap;
            if (wrap) begin
                pre      <= '0;
                idx      <= (idx == 3'(DIGITS - 1)) ? 3'd0 : idx + 3'd1;
                slot_cnt <= slot_cnt + BLINK_BITS'(1);
            end else begin
                pre <= pre + PW'(1);
            end
            if (upd) begin
                digit_o   <= {dp_mask[idx], value[{idx, 2'b00} +: 4]};
                anode_n_o <= suppress ? '1 : ~(DIGITS'(1) << idx);
            end
        end
    end

endmodule

// File: tb/tb_hexdisp_scan.sv
// tb_hexdisp_scan: directed bench for hexdisp_scan with PRESCALE=4,
// BLINK_BITS=2, DIGITS=8. A scan slot lasts 4 cycles; slot s covers ticks
// 4s+1 .. 4s+4 counted from reset release, and its index is s mod 8.
module tb_hexdisp_scan;
    localparam int DIGITS     = 8;
    localparam int PRESCALE   = 4;
    localparam int BLINK_BITS = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hexdisp_scan_if wb ();
    logic [4:0]        digit;
    logic [DIGITS-1:0] anode;

    hexdisp_scan #(
        .DIGITS    (DIGITS),
        .PRESCALE  (PRESCALE),
        .BLINK_BITS(BLINK_BITS)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .wb       (wb),
        .digit_o  (digit),
        .anode_n_o(anode)
    );

    int unsigned tick;
    always @(posedge clk) begin
        if (rst) tick <= 0;
        else     tick <= tick + 1;
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [12:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic bus_idle();
        wb.cyc_i = 1'b0;
        wb.stb_i = 1'b0;
        wb.we_i  = 1'b0;
        wb.adr_i = 2'd0;
        wb.sel_i = 4'h0;
        wb.dat_i = 32'h0;
    endtask

    task automatic bus_xfer(input logic we, input logic [1:0] adr, input logic [3:0] sel,
                            input logic [31:0] wdat, output logic [31:0] rdat);
        @(negedge clk);
        wb.cyc_i = 1'b1;
        wb.stb_i = 1'b1;
        wb.we_i  = we;
        wb.adr_i = adr;
        wb.sel_i = sel;
        wb.dat_i = wdat;
        @(negedge clk);
        chk("ack_rise", {31'b0, wb.ack_o}, 32'd1);
        rdat = wb.dat_o;
        bus_idle();
        @(negedge clk);
        chk("ack_pulse", {31'b0, wb.ack_o}, 32'd0);
    endtask

    task automatic wr(input logic [1:0] adr, input logic [3:0] sel, input logic [31:0] d);
        logic [31:0] r;
        bus_xfer(1'b1, adr, sel, d, r);
    endtask

    task automatic rd(input logic [1:0] adr, input logic [31:0] exp, input string tag);
        logic [31:0] r;
        bus_xfer(1'b0, adr, 4'hF, 32'h0, r);
        chk(tag, r, exp);
    endtask

    // Advance to the middle of the next scan slot.
    task automatic next_slot(output int idx, output int slot);
        int n = 0;
        @(negedge clk);
        while ((tick % 4) != 2 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) chk("slot_timeout", 32'd0, 32'd1);
        slot = int'((tick - 1) / 4);
        idx  = slot % DIGITS;
    endtask

    task automatic scan_check(input string tag, input logic [7:0] an_t[8],
                              input logic [4:0] dg_t[8], input bit blink, input int nslots);
        int i, s;
        logic [7:0]  a;
        logic [12:0] e;
        for (int k = 0; k < nslots; k++) begin
            next_slot(i, s);
            a = an_t[i];
            if (blink && (s % 4) >= 2) a = 8'hFF;
            exp_q.push_back({a, dg_t[i]});
            e = exp_q.pop_front();
            chk($sformatf("%s_idx%0d", tag, i), {19'b0, anode, digit}, {19'b0, e});
        end
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] an_seq[8]  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] an_off[8]  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [4:0] dg_1234[8] = '{5'h08, 5'h07, 5'h06, 5'h05, 5'h04, 5'h03, 5'h02, 5'h01};
    logic [7:0] an_lz[8]   = '{8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [4:0] dg_lz[8]   = '{5'h00, 5'h0A, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00};
    logic [7:0] an_lzdp[8] = '{8'hFE, 8'hFD, 8'hFF, 8'hF7, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [4:0] dg_lzdp[8] = '{5'h00, 5'h0A, 5'h00, 5'h10, 5'h00, 5'h00, 5'h00, 5'h00};

    initial begin
        int i, s;
        logic [31:0] r;
        bus_idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_anode", {24'b0, anode}, 32'hFF);
        chk("rst_digit", {27'b0, digit}, 32'h0);
        chk("rst_ack",   {31'b0, wb.ack_o}, 32'h0);
        chk("rst_dat",   wb.dat_o, 32'h0);
        rst = 1'b0;

        // First slot appears one cycle after release, then steps every 4.
        @(negedge clk);
        chk("first_anode", {24'b0, anode}, 32'hFE);
        repeat (3) @(negedge clk);
        chk("slot0_hold", {24'b0, anode}, 32'hFE);
        @(negedge clk);
        chk("slot1_step", {24'b0, anode}, 32'hFD);

        // Plain scan of 0x12345678, including the wrap back to digit 0.
        wr(2'd0, 4'hF, 32'h1234_5678);
        rd(2'd0, 32'h1234_5678, "rd_value");
        rd(2'd1, 32'h0000_0400, "rd_ctrl_reset");
        next_slot(i, s);
        scan_check("scan", an_seq, dg_1234, 1'b0, 9);

        // Strobe without cycle is ignored.
        @(negedge clk);
        wb.stb_i = 1'b1; wb.we_i = 1'b1; wb.adr_i = 2'd0; wb.sel_i = 4'hF; wb.dat_i = 32'h0;
        @(negedge clk);
        chk("nocyc_ack0", {31'b0, wb.ack_o}, 32'd0);
        @(negedge clk);
        chk("nocyc_ack1", {31'b0, wb.ack_o}, 32'd0);
        bus_idle();
        rd(2'd0, 32'h1234_5678, "nocyc_value");

        // Leading-zero blanking, then a DP forcing digit 3 on.
        wr(2'd0, 4'hF, 32'h0000_00A0);
        wr(2'd1, 4'hF, 32'h0000_0500);
        next_slot(i, s);
        scan_check("lz", an_lz, dg_lz, 1'b0, 8);
        wr(2'd1, 4'hF, 32'h0000_0508);
        next_slot(i, s);
        scan_check("lzdp", an_lzdp, dg_lzdp, 1'b0, 8);

        // Byte lanes, control masking, reserved registers, pre-write read data.
        wr(2'd0, 4'hF, 32'h0);
        wr(2'd0, 4'h2, 32'hFFFF_FFFF);
        rd(2'd0, 32'h0000_FF00, "byte_lane");
        bus_xfer(1'b1, 2'd0, 4'hF, 32'h1111_2222, r);
        chk("write_old_dat", r, 32'h0000_FF00);
        rd(2'd0, 32'h1111_2222, "write_new");
        wr(2'd1, 4'hF, 32'hFFFF_FFFF);
        rd(2'd1, 32'h0000_07FF, "ctrl_mask");
        wr(2'd2, 4'hF, 32'hFFFF_FFFF);
        rd(2'd2, 32'h0, "reg2_zero");
        rd(2'd3, 32'h0, "reg3_zero");

        // Blink: 2 slots lit, 2 dark. Then display disabled.
        wr(2'd0, 4'hF, 32'h1234_5678);
        wr(2'd1, 4'hF, 32'h0000_0600);
        next_slot(i, s);
        scan_check("blink", an_seq, dg_1234, 1'b1, 8);
        wr(2'd1, 4'hF, 32'h0000_0000);
        next_slot(i, s);
        scan_check("disp_off", an_off, dg_1234, 1'b0, 4);

        // Held strobe acks every other cycle; reset aborts it.
        @(negedge clk);
        wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b0; wb.adr_i = 2'd1; wb.sel_i = 4'hF;
        @(negedge clk);
        chk("held_ack1", {31'b0, wb.ack_o}, 32'd1);
        @(negedge clk);
        chk("held_ack0", {31'b0, wb.ack_o}, 32'd0);
        @(negedge clk);
        chk("held_ack1b", {31'b0, wb.ack_o}, 32'd1);
        chk("held_dat", wb.dat_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ack",   {31'b0, wb.ack_o}, 32'd0);
        chk("mid_rst_anode", {24'b0, anode}, 32'hFF);
        chk("mid_rst_digit", {27'b0, digit}, 32'h0);
        chk("mid_rst_dat",   wb.dat_o, 32'h0);
        rst = 1'b0;
        bus_idle();
        @(negedge clk);
        chk("post_rst_idx0", {24'b0, anode}, 32'hFE);
        chk("post_rst_digit", {27'b0, digit}, 32'h0);
        rd(2'd0, 32'h0, "post_rst_value");
        rd(2'd1, 32'h0000_0400, "post_rst_ctrl");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
